// File: rtl/input_panel_pkg.sv
// Shared types and constants for the front-panel input block.
// Button FSM encoding and the default debounce tick period.
package input_panel_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESSED  = 2'd2
  } btn_state_e;

  localparam logic [15:0] DEBOUNCE_DEFAULT = 16'd60000;

endpackage

// File: rtl/input_panel_if.sv
// Processor-side bundle of the input panel.
// The panel drives the switch values and exec; the core drives halting.
interface input_panel_if;

  logic        halting;
  logic [15:0] inpval1;
  logic [15:0] inpval2;
  logic        exec;

  modport master (
    input  halting,
    output inpval1,
    output inpval2,
    output exec
  );

  modport slave (
    output halting,
    input  inpval1,
    input  inpval2,
    input  exec
  );

endinterface

// File: rtl/input_panel_debounce_bank.sv
// Two-flop synchronizer plus tick-sampled debouncer, one lane per bit.
// A bit's debounced value moves only when two successive tick samples agree.
module debounce_bank #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             use_clock,
  input  logic             n_reset,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] deb_o
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] deb_q, deb_d;
  logic [WIDTH-1:0] agree;

  assign agree = ~(sync2_q ^ samp_q);

  always_comb begin
    samp_d = samp_q;
    deb_d  = deb_q;
    if (tick_i) begin
      samp_d = sync2_q;
      deb_d  = (agree & sync2_q) | (~agree & deb_q);
    end
  end

  always_ff @(posedge use_clock) begin
    if (!n_reset) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
      samp_q  <= RESET_VAL;
      deb_q   <= RESET_VAL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      samp_q  <= samp_d;
      deb_q   <= deb_d;
    end
  end

  assign deb_o = deb_q;

endmodule

// File: rtl/input_panel.sv
// Front-panel switches and exec button: debounced switch values to the
// core, plus a one-cycle exec pulse per fresh button press while halted.
module input_panel
  import input_panel_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                 use_clock,
  input  logic                 n_reset,
  input  logic [15:0]          sw_a,
  input  logic [7:0]           sw_b,
  input  logic                 n_btn_exec,
  input_panel_if.master        cpu
);

  logic [15:0] cnt_q, cnt_d;
  logic        tick;

  assign tick  = (cnt_q == DEBOUNCE_CYCLES - 16'd1);
  assign cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

  always_ff @(posedge use_clock) begin
    if (!n_reset) cnt_q <= 16'd0;
    else          cnt_q <= cnt_d;
  end

  logic [23:0] sw_deb;
  logic        btn_rel;

  debounce_bank #(
    .WIDTH     (24),
    .RESET_VAL (24'h0)
  ) u_sw (
    .use_clock (use_clock),
    .n_reset   (n_reset),
    .tick_i    (tick),
    .raw_i     ({sw_b, sw_a}),
    .deb_o     (sw_deb)
  );

  debounce_bank #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_btn (
    .use_clock (use_clock),
    .n_reset   (n_reset),
    .tick_i    (tick),
    .raw_i     (n_btn_exec),
    .deb_o     (btn_rel)
  );

  logic [15:0] inpval1_q;
  logic [15:0] inpval2_q;

  always_ff @(posedge use_clock) begin
    if (!n_reset) begin
      inpval1_q <= 16'h0;
      inpval2_q <= 16'h0;
    end else begin
      inpval1_q <= sw_deb[15:0];
      inpval2_q <= {8'h00, sw_deb[23:16]};
    end
  end

  // The button debouncer resets to "released" without having seen the pin;
  // hold WAIT_REL until three ticks have refreshed it from the real input.
  btn_state_e  state_q;
  logic        exec_q;
  logic [1:0]  arm_q;
  logic        armed;

  assign armed = (arm_q == 2'd3);

  always_ff @(posedge use_clock) begin
    if (!n_reset) begin
      state_q <= WAIT_REL;
      exec_q  <= 1'b0;
      arm_q   <= 2'd0;
    end else begin
      exec_q <= 1'b0;
      if (tick && !armed) arm_q <= arm_q + 2'd1;
      unique case (state_q)
        WAIT_REL: if (armed && btn_rel) state_q <= IDLE;
        IDLE: begin
          if (!btn_rel) begin
            state_q <= PRESSED;
            exec_q  <= cpu.halting;
          end
        end
        PRESSED:  if (btn_rel) state_q <= IDLE;
        default:  state_q <= WAIT_REL;
      endcase
    end
  end

  assign cpu.inpval1 = inpval1_q;
  assign cpu.inpval2 = inpval2_q;
  assign cpu.exec    = exec_q;

endmodule

// File: tb/tb_input_panel.sv
// Directed bench for input_panel with a 4-cycle debounce tick.
// Exec pulses are counted by a negedge monitor; vectors compare deltas.
module tb_input_panel;
  import input_panel_pkg::*;

  logic        use_clock = 1'b0;
  logic        n_reset;
  logic [15:0] sw_a;
  logic [7:0]  sw_b;
  logic        n_btn_exec;

  input_panel_if cpu ();

  input_panel #(
    .DEBOUNCE_CYCLES (16'd4)
  ) dut (
    .use_clock  (use_clock),
    .n_reset    (n_reset),
    .sw_a       (sw_a),
    .sw_b       (sw_b),
    .n_btn_exec (n_btn_exec),
    .cpu        (cpu.master)
  );

  always #5 use_clock = ~use_clock;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge use_clock);
  endtask

  int   pulses = 0;
  int   wide   = 0;
  logic exec_prev = 1'b0;

  always @(negedge use_clock) begin
    if (cpu.exec === 1'b1) begin
      if (exec_prev) wide++;
      else           pulses++;
    end
    exec_prev = (cpu.exec === 1'b1);
  end

  int   p0, w0;
  logic seen;
  logic found;

  initial begin
    n_reset     = 1'b0;
    sw_a        = 16'hA5C3;
    sw_b        = 8'h7E;
    n_btn_exec  = 1'b1;
    cpu.halting = 1'b0;
    cyc(3);
    chk("rst_inpval1", 32'(cpu.inpval1), 32'h0);
    chk("rst_inpval2", 32'(cpu.inpval2), 32'h0);
    chk("rst_exec", 32'(cpu.exec), 32'h0);

    n_reset = 1'b1;
    cyc(11);
    chk("sw_inpval1", 32'(cpu.inpval1), 32'hA5C3);
    chk("sw_inpval2", 32'(cpu.inpval2), 32'h007E);

    sw_a = 16'hA5C2;
    cyc(20);
    chk("sw_base", 32'(cpu.inpval1), 32'hA5C2);
    sw_a = 16'hA5C3;
    cyc(1);
    sw_a = 16'hA5C2;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(1);
      seen = seen | cpu.inpval1[0];
    end
    chk("glitch_bit0", 32'(seen), 32'h0);
    chk("glitch_word", 32'(cpu.inpval1), 32'hA5C2);

    sw_b = 8'h81;
    cyc(12);
    chk("sw_b_hi_zero", 32'(cpu.inpval2), 32'h0081);

    cpu.halting = 1'b1;
    p0 = pulses;
    w0 = wide;
    for (int i = 0; i < 3; i++) begin
      n_btn_exec = 1'b0;
      cyc(1);
      n_btn_exec = 1'b1;
      cyc(1);
    end
    n_btn_exec = 1'b0;
    cyc(50);
    chk("bounce_pulses", 32'(pulses - p0), 32'd1);
    chk("bounce_width", 32'(wide - w0), 32'd0);
    n_btn_exec = 1'b1;
    cyc(20);
    chk("release_quiet", 32'(pulses - p0), 32'd1);

    cpu.halting = 1'b0;
    p0 = pulses;
    n_btn_exec = 1'b0;
    cyc(20);
    n_btn_exec = 1'b1;
    cyc(20);
    cpu.halting = 1'b1;
    cyc(10);
    chk("nohalt_consumed", 32'(pulses - p0), 32'd0);
    n_btn_exec = 1'b0;
    cyc(20);
    chk("second_press", 32'(pulses - p0), 32'd1);
    n_btn_exec = 1'b1;
    cyc(20);

    p0 = pulses;
    n_btn_exec = 1'b0;
    n_reset = 1'b0;
    cyc(3);
    n_reset = 1'b1;
    cyc(40);
    chk("held_thru_rst", 32'(pulses - p0), 32'd0);
    n_btn_exec = 1'b1;
    cyc(20);
    n_btn_exec = 1'b0;
    cyc(20);
    chk("repress_after_rst", 32'(pulses - p0), 32'd1);

    n_btn_exec = 1'b1;
    cyc(20);
    n_btn_exec = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge use_clock);
      found = (cpu.exec === 1'b1);
    end
    chk("exec_seen", 32'(found), 32'h1);
    n_reset = 1'b0;
    cyc(1);
    chk("rst_kills_exec", 32'(cpu.exec), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(WAIT_REL));
    cyc(2);
    n_reset = 1'b1;
    p0 = pulses;
    cyc(40);
    chk("post_rst_quiet", 32'(pulses - p0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/input_panel.md
INPUT_PANEL -- requirements
Module: input_panel

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd60000, is the sample-tick period in use_clock cycles (1 ms at 60 MHz); legal range 2..65535.
REQ-002 use_clock  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 n_reset  input  1  reset; synchronous, active-low.
REQ-004 sw_a  input  16  raw asynchronous switch bank A.
REQ-005 sw_b  input  8  raw asynchronous switch bank B.
REQ-006 n_btn_exec  input  1  raw asynchronous exec push-button; active-low (0 = pressed).
REQ-007 halting  input  1  high while the processor is halted and can accept exec.
REQ-008 inpval1  output  16  debounced sw_a.
REQ-009 inpval2  output  16  {8'b0, debounced sw_b}.
REQ-010 exec  output  1  single-cycle start pulse to the processor.

Function
REQ-011 Every raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-012 A free-running 16-bit tick counter SHALL count 0..DEBOUNCE_CYCLES-1 and wrap, asserting an internal tick for exactly one cycle at the wrap.
REQ-013 On each tick, each synchronized bit SHALL be sampled; its debounced value SHALL update only when the current and previous tick samples agree.
REQ-014 A level held stable for at least 2*DEBOUNCE_CYCLES+3 cycles SHALL appear on the debounced output; a glitch shorter than DEBOUNCE_CYCLES-2 cycles SHALL never appear.
REQ-015 inpval1 and inpval2 SHALL be registered and SHALL track their debounced bits continuously, with no latching at exec.
REQ-016 inpval2[15:8] SHALL be constant 0.
REQ-017 Button FSM states: WAIT_REL, IDLE, PRESSED.
REQ-018 WAIT_REL -> IDLE when the debounced button is released; otherwise the FSM stays in WAIT_REL.
REQ-019 IDLE -> PRESSED when the debounced button is pressed; exec SHALL pulse high for exactly one cycle on that transition if halting=1 in the same cycle.
REQ-020 A press taken while halting=0 SHALL still move the FSM to PRESSED without a pulse; the press is consumed, not queued.
REQ-021 PRESSED -> IDLE on a debounced release; a held button SHALL produce no further pulses.
REQ-022 exec SHALL be a registered output, asserted one cycle after the debounced press is registered.
REQ-023 If halting changes in the press cycle, the value sampled in that cycle SHALL decide whether the pulse is issued.

Reset
REQ-024 While n_reset=0 at a clock edge, the block SHALL load: inpval1=0, inpval2=0, exec=0, tick counter=0, switch sample and debounce registers=0, button sync/sample/debounce registers=1 (released), FSM=WAIT_REL.
REQ-025 A button held through reset release SHALL not generate exec until it is released and pressed again.
REQ-026 Reset asserted mid-debounce or mid-pulse SHALL take priority and SHALL clear exec in the same edge.

Structure
REQ-027 A shared package input_panel_pkg SHALL hold the FSM state encoding (2-bit) and the DEBOUNCE_CYCLES default constant.
REQ-028 A sub-module debounce_bank, parameterized by WIDTH and RESET_VAL, SHALL implement REQ-011 and REQ-013; it SHALL be instantiated once for 24 switch bits and once for the button, with both instances sharing a single tick.
REQ-029 The implementation SHALL contain no latches, no derived clocks, and no combinational path from input to output.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 Reset, then sw_a=16'hA5C3 and sw_b=8'h7E held stable -> within 11 cycles inpval1=16'hA5C3 and inpval2=16'h007E; both 0 during reset.
REQ-031 sw_a[0] glitched high for 1 cycle between ticks -> inpval1[0] stays 0 for 40 cycles.
REQ-032 halting=1, button pressed with 3 bounces of 1 cycle each, then held 50 cycles -> exactly one exec pulse of width 1.
REQ-033 halting=0, press then release, then halting=1 -> no exec pulse; a second press -> exactly one pulse.
REQ-034 Button held through n_reset deassertion -> no exec pulse; after release and re-press -> one pulse.
REQ-035 n_reset asserted in the cycle exec=1 -> exec=0 on the next edge and FSM=WAIT_REL.
